// File: rtl/enigma_uart_pkg.sv
// Shared definitions for the UART frame monitor: parity modes, FSM states,
// and the default bit period for the 12 MHz system clock.
package enigma_uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // 12 MHz / 115200 baud, truncated
    localparam int DEFAULT_CLKS_PER_BIT = 12_000_000 / 115_200;

    typedef enum logic [2:0] {
        ST_BREAK_WAIT,
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_COMMIT
    } uart_mon_state_t;

endpackage

// File: rtl/uart_mon_fifo.sv
// Synchronous first-word-fall-through FIFO with same-cycle push/pop and an
// occupancy count. The head reads as zero while empty.
module uart_mon_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // a pop on a full FIFO frees the slot for a same-cycle push
    assign do_push = push && (!full || do_pop);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/uart_frame_monitor.sv
// UART line monitor: deserialises line_in into a FWFT FIFO and flags/counts
// framing, parity and overflow errors.
module uart_frame_monitor
    import enigma_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = PAR_NONE,
    parameter int STOP_BITS    = 1,
    parameter int DEPTH        = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   line_in,
    input  logic                   rd_en,
    input  logic                   clear_errors,
    output logic [DATA_BITS-1:0]   rd_data,
    output logic                   rd_valid,
    output logic [$clog2(DEPTH):0] count,
    output logic                   busy,
    output logic                   frame_err,
    output logic                   parity_err,
    output logic                   overflow,
    output logic [15:0]            err_count
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

    logic                 sync1, sync2, sync_d;
    logic [1:0]           settle;
    uart_mon_state_t      state;
    logic [CW-1:0]        bit_cnt;
    logic [3:0]           bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 tick, start_edge, parity_bad;
    logic                 push, fifo_full, fifo_empty;

    // settle gates BREAK_WAIT until the synchroniser has flushed its reset ones,
    // so a line held low through reset cannot look like a start edge
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            sync_d <= 1'b1;
            settle <= '0;
        end else begin
            sync1  <= line_in;
            sync2  <= sync1;
            sync_d <= sync2;
            if (settle != 2'd2) begin
                settle <= settle + 2'd1;
            end
        end
    end

    assign tick       = (bit_cnt == '0);
    assign start_edge = sync_d && !sync2;
    assign parity_bad = (PARITY != PAR_NONE) && ((^shreg ^ par_bit) != (PARITY == PAR_ODD));
    assign push       = (state == ST_COMMIT) && enable && !parity_bad && (!fifo_full || rd_en);
    assign rd_valid   = !fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_BREAK_WAIT;
            busy       <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overflow   <= 1'b0;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
        end else begin
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overflow   <= 1'b0;
            if (busy && !enable) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    ST_BREAK_WAIT: if (settle == 2'd2 && sync2) state <= ST_IDLE;
                    ST_IDLE: begin
                        if (enable && start_edge) begin
                            state   <= ST_START;
                            busy    <= 1'b1;
                            bit_cnt <= HALF_LOAD;
                        end
                    end
                    ST_START: begin
                        if (!tick) begin
                            bit_cnt <= bit_cnt - 1'b1;
                        end else if (sync2) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state   <= ST_DATA;
                            bit_cnt <= BIT_LOAD;
                            bit_idx <= '0;
                        end
                    end
                    ST_DATA: begin
                        if (!tick) begin
                            bit_cnt <= bit_cnt - 1'b1;
                        end else begin
                            shreg   <= {sync2, shreg[DATA_BITS-1:1]};
                            bit_cnt <= BIT_LOAD;
                            if (bit_idx == DATA_LAST) begin
                                bit_idx <= '0;
                                state   <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                            end else begin
                                bit_idx <= bit_idx + 4'd1;
                            end
                        end
                    end
                    ST_PARITY: begin
                        if (!tick) begin
                            bit_cnt <= bit_cnt - 1'b1;
                        end else begin
                            par_bit <= sync2;
                            bit_cnt <= BIT_LOAD;
                            state   <= ST_STOP;
                        end
                    end
                    ST_STOP: begin
                        if (!tick) begin
                            bit_cnt <= bit_cnt - 1'b1;
                        end else if (!sync2) begin
                            frame_err <= 1'b1;
                            state     <= ST_BREAK_WAIT;
                            busy      <= 1'b0;
                        end else if (bit_idx == STOP_LAST) begin
                            state <= ST_COMMIT;
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                            bit_cnt <= BIT_LOAD;
                        end
                    end
                    ST_COMMIT: begin
                        parity_err <= parity_bad;
                        overflow   <= !parity_bad && fifo_full && !rd_en;
                        state      <= ST_IDLE;
                        busy       <= 1'b0;
                    end
                    default: begin
                        state <= ST_BREAK_WAIT;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear_errors) begin
            err_count <= '0;
        end else if ((frame_err || parity_err || overflow) && err_count != '1) begin
            err_count <= err_count + 16'd1;
        end
    end

    uart_mon_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (shreg),
        .pop     (rd_en),
        .rd_data (rd_data),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (count)
    );

endmodule

// File: doc/uart_frame_monitor.md
# uart_frame_monitor

Synthesizable UART line monitor that deserialises an asynchronous serial line, such as the design's own `uart_tx` pin looped back or an external `uart_rx`, into a first-word-fall-through (FWFT) FIFO. It also flags and counts framing errors, parity errors and overflows. It is the parametrised successor of the current fixed 8N1, single-purpose receive path: frame format, baud divisor and buffer depth are configurable. It sits beside `enigma_top`'s UART pins for on-chip debug capture and self-check of banner and cipher output.

## Interface
- `CLKS_PER_BIT`, 104: clock cycles per bit (12 MHz / 115200); must be ≥ 8.
- `DATA_BITS`, 8: data bits per frame, 5..9, LSB first.
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: 1 or 2.
- `DEPTH`, 16: FIFO entries; power of two, ≥ 2.
- `clk` in 1: system clock.
- `rst` in 1: reset; synchronous, active-high.
- `enable` in 1: deserialiser run enable.
- `line_in` in 1: asynchronous serial line; idle high.
- `rd_en` in 1: pop the head entry.
- `clear_errors` in 1: zero `err_count`.
- `rd_data` out DATA_BITS: FIFO head; valid when `rd_valid` = 1.
- `rd_valid` out 1: FIFO non-empty.
- `count` out $clog2(DEPTH)+1: FIFO occupancy.
- `busy` out 1: frame in progress (state ≠ IDLE/BREAK_WAIT).
- `frame_err` out 1: one-cycle pulse.
- `parity_err` out 1: one-cycle pulse.
- `overflow` out 1: one-cycle pulse.
- `err_count` out 16: saturating error counter.

## Operation
- `line_in` passes through a 2-FF synchroniser, which resets to 1. A start edge is the synchronised value being 0 after being 1.
- FSM states: BREAK_WAIT, IDLE, START, DATA, PARITY, STOP, COMMIT.
- BREAK_WAIT: hold until the synchronised line is 1, then go to IDLE. BREAK_WAIT is the reset state.
- IDLE: on a start edge with `enable` = 1, go to START and load the bit counter.
- START: at the half-bit point, re-sample the line.
  - Line 0: go to DATA.
  - Line 1: glitch; return to IDLE with no error.
- DATA: sample `DATA_BITS` bits, shifting LSB first.
- PARITY (present only when `PARITY` ≠ 0): sample one bit and check it against the XOR of the data bits (even or odd per `PARITY`).
- STOP: sample `STOP_BITS` bits.
  - Any stop bit 0: raise `frame_err`, discard the byte, go to BREAK_WAIT.
- COMMIT (one cycle): evaluate in priority order:
  - Parity bad: raise `parity_err` and discard the byte.
  - FIFO full and no pop this cycle: raise `overflow` and discard the byte; FIFO contents are unchanged.
  - Otherwise: push the byte.
  - Then go to IDLE.
- `enable` = 0 in any active state: abort to IDLE with no pulse and no push. The FIFO stays readable.
- FIFO rules:
  - Push and pop in the same cycle are both legal.
  - A pop on a full FIFO frees the slot for a same-cycle push, so no overflow occurs.
  - `rd_en` while empty is ignored.
- `err_count`:
  - +1 per cycle in which any error pulse is high.
  - Saturates at 16'hFFFF.
  - `clear_errors` wins over a same-cycle increment.

## Timing
- t0 is the first cycle in which the synchroniser output is 0. t0 is 2 clocks after `line_in` falls.
- Start-bit sample: t0 + CLKS_PER_BIT/2 (integer division).
- Frame bit k (k = 0 is the first data bit): sampled at t0 + CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT.
- The last stop bit is sampled at ts = t0 + CLKS_PER_BIT/2 + (DATA_BITS + P + STOP_BITS)·CLKS_PER_BIT, where P = (PARITY ≠ 0).
- COMMIT occurs at ts+1.
- `rd_valid`, `count`, `parity_err` and `overflow` update at ts+2. `frame_err` updates at ts+1.
- IDLE is re-entered at ts+2, mid stop bit, so back-to-back frames are accepted.
- `rd_en` at cycle n: `rd_data` shows the next entry, and `count` decrements, at n+1.
- Reset values: `rd_valid`=0, `count`=0, `busy`=0, all pulses 0, `err_count`=0, `rd_data`=0.
- Reset mid-frame: the frame is dropped and the FIFO emptied. If the line is still low after reset, the block waits in BREAK_WAIT; no false start is detected.

## Structure
- Package `enigma_uart_pkg` holds:
  - parity-mode constants `PAR_NONE`, `PAR_EVEN`, `PAR_ODD`;
  - the FSM state enum `uart_mon_state_t`;
  - the default `CLKS_PER_BIT` for the 12 MHz clock.
- One sub-module, `uart_mon_fifo`: synchronous FWFT FIFO parametrised by `WIDTH` and `DEPTH`, with same-cycle push/pop and an occupancy count.

## Test plan
- 8N1 at 104 clks/bit, send 0x45 then 0x0A back-to-back:
  - `rd_valid` rises at ts+2 of the first frame.
  - Pops return 0x45 then 0x0A.
  - `err_count` = 0.
- PARITY=1 (even), send 0x03 with parity 1:
  - `parity_err` pulses once; nothing is pushed.
  - Resend with parity 0: 0x03 is pushed.
- Stop bit forced to 0 on 0x55:
  - `frame_err` pulses once; the FIFO stays empty.
  - Line held low 3 bit-times: no further frames are captured.
  - Next valid frame 0x41 is captured correctly.
- DEPTH=4, send 5 frames with no reads:
  - `count` = 4; `overflow` pulses once on the 5th frame.
  - Pops return the first 4 bytes in order.
  - Repeat with `rd_en` asserted at the 5th COMMIT: no overflow.
- 20-cycle low glitch, shorter than the half-bit of 52 cycles:
  - Nothing is pushed, no error pulse, `busy` back to 0.
  - `rst` asserted at data bit 3 of a frame: all outputs return to reset values and the partial byte is never pushed.
- Force `err_count` to 16'hFFFE, inject 3 framing errors: it holds at 16'hFFFF.
  - `clear_errors` asserted in the same cycle as an error pulse: `err_count` = 0.
